// File: rtl/nor_alu_pkg.sv
// Shared opcode and FSM state encodings for the NOR-only logic unit and its
// bit-serial sequencer.
package nor_alu_pkg;

  // Opcodes understood by the 1-bit cell; 6 and 7 both select NAND.
  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_NOR  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NAND = 3'd6;

  // Sequencer states, 2-bit binary.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/nor_logic_cell.sv
// Combinational 1-bit logic unit. Every function row is built from two-input
// NOR gates; the opcode only steers which row reaches the output.
module nor_logic_cell
  import nor_alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic [2:0] sel_i,
  output logic       out_o
);

  wire n_a;
  wire n_b;
  wire n_ab;
  wire n_or;
  wire n_and;
  wire n_lo;
  wire n_hi;
  wire n_xnor;
  wire n_xor;
  wire n_nand;

  nor g_na   (n_a,    a_i,    a_i);
  nor g_nb   (n_b,    b_i,    b_i);
  nor g_nor  (n_ab,   a_i,    b_i);
  nor g_or   (n_or,   n_ab,   n_ab);
  nor g_and  (n_and,  n_a,    n_b);
  // n_lo = ~a & b, n_hi = a & ~b; their NOR is XNOR.
  nor g_lo   (n_lo,   a_i,    n_ab);
  nor g_hi   (n_hi,   b_i,    n_ab);
  nor g_xnor (n_xnor, n_lo,   n_hi);
  nor g_xor  (n_xor,  n_xnor, n_xnor);
  nor g_nand (n_nand, n_and,  n_and);

  // Row select; opcodes 6 and 7 fall through to NAND.
  always_comb begin
    out_o = n_nand;
    case (sel_i)
      OP_NOT:  out_o = n_a;
      OP_NOR:  out_o = n_ab;
      OP_AND:  out_o = n_and;
      OP_OR:   out_o = n_or;
      OP_XOR:  out_o = n_xor;
      OP_XNOR: out_o = n_xnor;
      default: out_o = n_nand;
    endcase
  end

endmodule

// File: rtl/nor_alu_serial_ctrl.sv
// Bit-serial sequencer: accepts a WIDTH-bit job over valid/ready, feeds the
// 1-bit NOR cell LSB first for WIDTH cycles, then offers the assembled result
// over a second valid/ready handshake. One job in flight at a time.
module nor_alu_serial_ctrl
  import nor_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // RUN exits on the last bit, so the index never has to wrap.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [1:0]       state_q,   state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] a_q,       a_d;
  logic [WIDTH-1:0] b_q,       b_d;
  logic [2:0]       op_q,      op_d;
  logic [WIDTH-1:0] result_q,  result_d;

  logic cell_a;
  logic cell_b;
  logic cell_out;

  assign cell_a = a_q[bit_idx_q];
  assign cell_b = b_q[bit_idx_q];

  nor_logic_cell u_cell (
    .a_i   (cell_a),
    .b_i   (cell_b),
    .sel_i (op_q),
    .out_o (cell_out)
  );

  // Next-state logic: accept in IDLE, one result bit per RUN cycle, hold in DONE.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    result_d  = result_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d       = a;
          b_d       = b;
          op_d      = op;
          result_d  = '0;
          bit_idx_d = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d[bit_idx_q] = cell_out;
        if (bit_idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          bit_idx_d = bit_idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        // The release cycle itself never accepts; IDLE is entered first.
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state in one process; reset abandons any job and clears the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      result_q  <= result_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_nor_alu_serial_ctrl.sv
// Bench for nor_alu_serial_ctrl: directed jobs with hand-computed results,
// expected values queued at issue and popped by an independent output monitor.
module tb_nor_alu_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       busy;

  // WIDTH=1 instance
  logic       in_valid1;
  logic       in_ready1;
  logic [2:0] op1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       out_valid1;
  logic       out_ready1;
  logic [0:0] result1;
  logic       busy1;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nor_alu_serial_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  nor_alu_serial_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .op(op1), .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // Output monitor: every completed output handshake pops one expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        timeout("unexpected_output");
      end else begin
        check("scoreboard_result", 32'(result), 32'(exp_q.pop_front()));
      end
    end
  end

  // Wait (at negedge) for in_ready, present a job for one edge; returns accept edge.
  task automatic issue(input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] e, input bit push, output int t_acc);
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) timeout("issue_in_ready");
    op = o; a = va; b = vb; in_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    t_acc = cyc;
    in_valid = 1'b0;
  endtask

  // Wait (at negedge) until out_valid; returns edge count seen.
  task automatic wait_out(output int t_seen);
    int g = 0;
    @(negedge clk);
    while (!out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!out_valid) timeout("wait_out_valid");
    t_seen = cyc;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t_acc;
    int t_seen;
    int acc[2];
    int n;
    int g;
    logic [7:0] sweep_exp[8];
    sweep_exp = '{8'h33, 8'h11, 8'h88, 8'hEE, 8'h66, 8'h99, 8'h77, 8'h77};

    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    in_valid1 = 1'b0; op1 = '0; a1 = '0; b1 = '0; out_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_w1_in_ready", 32'(in_ready1), 32'd1);

    // 1: AND with latency; out_valid registered at the edge after the one observed
    issue(3'd2, 8'hCC, 8'hAA, 8'h88, 1'b1, t_acc);
    @(negedge clk);
    check("and_busy_in_run", 32'(busy), 32'd1);
    check("and_in_ready_in_run", 32'(in_ready), 32'd0);
    wait_out(t_seen);
    check("and_latency", 32'(t_seen + 1 - t_acc), 32'd9);
    @(negedge clk);
    check("and_out_valid_one_cycle", 32'(out_valid), 32'd0);
    check("and_in_ready_after", 32'(in_ready), 32'd1);

    // 2: op sweep, plus op 0 with different b
    for (int i = 0; i < 8; i++) begin
      issue(3'(i), 8'hCC, 8'hAA, sweep_exp[i], 1'b1, t_acc);
      wait_out(t_seen);
    end
    issue(3'd0, 8'hCC, 8'h00, 8'h33, 1'b1, t_acc);
    wait_out(t_seen);
    issue(3'd0, 8'hCC, 8'hFF, 8'h33, 1'b1, t_acc);
    wait_out(t_seen);
    drain();

    // 3: backpressure with a stray in_valid in the window
    out_ready = 1'b0;
    issue(3'd2, 8'hCC, 8'hAA, 8'h88, 1'b1, t_acc);
    wait_out(t_seen);
    @(posedge clk);
    #1;
    op = 3'd1; a = 8'h00; b = 8'h00; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_result", 32'(result), 32'h88);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      if (k == 2) in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_released_busy", 32'(busy), 32'd0);
    check("bp_released_in_ready", 32'(in_ready), 32'd1);
    drain();

    // 4: input churn during RUN; 5A ^ 0F = 55
    issue(3'd4, 8'h5A, 8'h0F, 8'h55, 1'b1, t_acc);
    g = 0;
    while (!out_valid && g < 50) begin
      op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      @(posedge clk);
      #1;
      g++;
    end
    if (!out_valid) timeout("churn_out_valid");
    drain();

    // 5: reset while bit_idx==3 (three RUN edges after accept)
    issue(3'd2, 8'hFF, 8'hFF, 8'h00, 1'b0, t_acc);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    issue(3'd4, 8'hF0, 8'h3C, 8'hCC, 1'b1, t_acc);
    wait_out(t_seen);
    drain();

    // 6: back-to-back with in_valid held high
    @(posedge clk);
    #1;
    op = 3'd2; a = 8'hCC; b = 8'hAA; in_valid = 1'b1;
    n = 0; g = 0;
    while (n < 2 && g < 100) begin
      @(negedge clk);
      if (in_ready) begin
        acc[n] = cyc + 1;
        exp_q.push_back(8'h88);
        n++;
      end
      @(posedge clk);
      #1;
      g++;
    end
    in_valid = 1'b0;
    if (n < 2) timeout("b2b_accepts");
    else check("b2b_spacing", 32'(acc[1] - acc[0]), 32'd10);
    drain();

    // WIDTH=1 build: NOR(0,0)=1, out_valid observed by accept+2
    @(negedge clk);
    op1 = 3'd1; a1 = 1'b0; b1 = 1'b0; in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    t_acc = cyc;
    in_valid1 = 1'b0;
    g = 0;
    @(negedge clk);
    while (!out_valid1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!out_valid1) timeout("w1_out_valid");
    else begin
      check("w1_latency", 32'(cyc + 1 - t_acc), 32'd2);
      check("w1_result", 32'(result1), 32'd1);
    end
    @(negedge clk);
    check("w1_back_idle", 32'(in_ready1), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
